program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_W, default 8, instruction word width written to program memory.
REQ-002 Parameter DEPTH, default 16, program memory locations (power of 2); AW = $clog2(DEPTH).
REQ-003 Parameter MAX_NEST, default 7, maximum bracket nesting depth.
REQ-004 clk_i  in  1  system clock, one clock domain.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  1  single-cycle pulse; begins (or restarts) a load.
REQ-007 rx_valid_i  in  1  upstream byte valid (UART RX side).
REQ-008 rx_data_i  in  8  upstream ASCII byte.
REQ-009 rx_ready_o  out  1  loader accepts byte this cycle.
REQ-010 wen_o / waddr_o / wdata_o  out  1 / AW / DATA_W  write port toward program memory.
REQ-011 busy_o, done_o, err_o  out  1 each  loading / completed / failed.
REQ-012 err_code_o  out  2  01 overflow, 10 unmatched ']', 11 unmatched '[' or nesting > MAX_NEST.
REQ-013 len_o  out  AW  instructions stored, excluding HALT terminator.

Function
REQ-014 FSM states IDLE, LOAD, DONE, ERR; byte transfer occurs when rx_valid_i && rx_ready_o.
REQ-015 rx_ready_o = 1 only in LOAD; busy_o = 1 only in LOAD.
REQ-016 Opcodes: HALT=0, '>'=1, '<'=2, '+'=3, '-'=4, '.'=5, ','=6, '['=7, ']'=8, zero-extended to DATA_W.
REQ-017 IDLE/DONE/ERR + start_i -> LOAD; write pointer=0, nest=0, done_o/err_o/err_code_o cleared.
REQ-018 start_i during LOAD restarts the load identically to REQ-017; the byte offered that cycle is not accepted.
REQ-019 Accepted BF char with pointer < DEPTH-1 -> write its opcode at pointer, then pointer+1.
REQ-020 Write outputs registered: byte accepted at cycle N -> wen_o=1 with address/data at N+1, wen_o one cycle wide.
REQ-021 Accepted non-BF byte other than terminator -> ignored, no write, LOAD retained.
REQ-022 Terminator '!' (0x21) or 0x00 -> write HALT at pointer, len_o=pointer, -> DONE.
REQ-023 Accepted BF char with pointer == DEPTH-1 -> no write, err_code 01, -> ERR (last slot reserved for HALT).
REQ-024 DONE: done_o=1 held, len_o held, until start_i.
REQ-025 ERR: err_o=1 and err_code_o held until start_i; wen_o never asserted in ERR.
REQ-026 Overflow check has priority over bracket checks for the same byte.
REQ-027 rx_ready_o is 0 in the cycle after terminator or error byte acceptance.

Reset
REQ-028 rst_i low at a clock edge -> IDLE, pointer=0, nest=0, all outputs 0, including mid-load.
REQ-029 Reset has priority over start_i and any handshake in the same cycle.

Configuration
REQ-030 Macro LOADER_BRACKET_CHECK_EN defined: '[' increments nest, ']' decrements nest; ']' at nest 0 -> err 10; '[' at nest MAX_NEST -> err 11; terminator with nest != 0 -> err 11, no HALT written; the offending byte is never written.
REQ-031 Macro undefined: no nest counter; brackets written unchecked; err codes 10/11 never produced.

Structure
REQ-032 Shared package holds opcode constants (REQ-016), terminator byte values, err code constants.
REQ-033 One combinational sub-module bf_char_decode: ASCII byte -> {is_bf, is_term, opcode}.

Verification
REQ-034 Reset, start_i, bytes "+>[-]!" -> writes addr 0..4 = 3,1,7,4,8; HALT at addr 5; done_o=1; len_o=5.
REQ-035 Bytes "+ a\n-!" -> only addr0=3, addr1=4, HALT at addr2; len_o=2.
REQ-036 DEPTH=16, 15 '+' then '+' -> 15 writes, err_o=1, err_code_o=01, no 16th write.
REQ-037 CHECK_EN: "]" -> err 10, no write; "[[+!" -> err 11, no HALT written.
REQ-038 rx_valid_i toggling each cycle with 3-cycle gaps -> wen_o exactly 1 cycle after each accepted byte.
REQ-039 rst_i low mid-load, then start_i, "+!" -> pointer restarts at 0, addr0=3, HALT at addr1.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants for the Brainfuck program loader: FSM states, opcodes,
// terminator bytes and error codes.
package program_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      ERR
   } state_t;

   localparam logic [3:0] OP_HALT  = 4'd0;
   localparam logic [3:0] OP_RIGHT = 4'd1;
   localparam logic [3:0] OP_LEFT  = 4'd2;
   localparam logic [3:0] OP_INC   = 4'd3;
   localparam logic [3:0] OP_DEC   = 4'd4;
   localparam logic [3:0] OP_OUT   = 4'd5;
   localparam logic [3:0] OP_IN    = 4'd6;
   localparam logic [3:0] OP_JZ    = 4'd7;
   localparam logic [3:0] OP_JNZ   = 4'd8;

   localparam logic [7:0] TERM_BANG = 8'h21;
   localparam logic [7:0] TERM_NUL  = 8'h00;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OVERFLOW = 2'b01;
   localparam logic [1:0] ERR_CLOSE    = 2'b10;
   localparam logic [1:0] ERR_NEST     = 2'b11;

endpackage

// File: rtl/program_loader_bf_char_decode.sv
// Combinational ASCII classifier: flags Brainfuck commands and load
// terminators, and maps commands to their program-memory opcode.
module bf_char_decode
   import program_loader_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_bf,
   output logic       is_term,
   output logic [3:0] opcode
);

   always_comb begin
      is_bf   = 1'b1;
      is_term = 1'b0;
      opcode  = OP_HALT;
      unique case (ch)
         8'h3E:     opcode = OP_RIGHT;
         8'h3C:     opcode = OP_LEFT;
         8'h2B:     opcode = OP_INC;
         8'h2D:     opcode = OP_DEC;
         8'h2E:     opcode = OP_OUT;
         8'h2C:     opcode = OP_IN;
         8'h5B:     opcode = OP_JZ;
         8'h5D:     opcode = OP_JNZ;
         TERM_BANG,
         TERM_NUL: begin
            is_bf   = 1'b0;
            is_term = 1'b1;
         end
         default:   is_bf = 1'b0;
      endcase
   end

endmodule

// File: rtl/program_loader.sv
// Streams ASCII Brainfuck from a UART-style byte source into program memory.
// Define LOADER_BRACKET_CHECK_EN to enable bracket nesting validation.
module program_loader
   import program_loader_pkg::*;
#(
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned DEPTH    = 16,
   parameter  int unsigned MAX_NEST = 7,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              rx_ready_o,
   output logic              wen_o,
   output logic [AW-1:0]     waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [AW-1:0]     len_o
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] ptr;
   logic          is_bf;
   logic          is_term;
   logic [3:0]    opcode;

   logic          accept;
   logic          bad_open;
   logic          bad_close;
   logic          bad_term;
   logic          do_write;
   logic          do_finish;
   logic          fault;
   logic [1:0]    fault_code;
   logic [3:0]    wr_op;

   bf_char_decode u_decode (
      .ch      (rx_data_i),
      .is_bf   (is_bf),
      .is_term (is_term),
      .opcode  (opcode)
   );

`ifdef LOADER_BRACKET_CHECK_EN
   localparam int unsigned NW = $clog2(MAX_NEST + 1);
   logic [NW-1:0] nest;

   always_comb begin
      bad_open  = (opcode == OP_JZ)  && (nest == NW'(MAX_NEST));
      bad_close = (opcode == OP_JNZ) && (nest == '0);
      bad_term  = (nest != '0);
   end
`else
   always_comb begin
      bad_open  = 1'b0;
      bad_close = 1'b0;
      bad_term  = 1'b0;
   end
`endif

   assign rx_ready_o = (state == LOAD);
   assign busy_o     = (state == LOAD);

   // Overflow is tested before bracket checks so a full buffer always reports 01.
   always_comb begin
      accept     = (state == LOAD) && rx_valid_i && !start_i;
      do_write   = 1'b0;
      do_finish  = 1'b0;
      fault      = 1'b0;
      fault_code = ERR_NONE;
      wr_op      = opcode;
      if (accept) begin
         if (is_term) begin
            if (bad_term) begin
               fault      = 1'b1;
               fault_code = ERR_NEST;
            end else begin
               do_write  = 1'b1;
               do_finish = 1'b1;
               wr_op     = OP_HALT;
            end
         end else if (is_bf) begin
            if (ptr == LAST) begin
               fault      = 1'b1;
               fault_code = ERR_OVERFLOW;
            end else if (bad_close) begin
               fault      = 1'b1;
               fault_code = ERR_CLOSE;
            end else if (bad_open) begin
               fault      = 1'b1;
               fault_code = ERR_NEST;
            end else begin
               do_write = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         ptr        <= '0;
         wen_o      <= 1'b0;
         waddr_o    <= '0;
         wdata_o    <= '0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
         len_o      <= '0;
`ifdef LOADER_BRACKET_CHECK_EN
         nest       <= '0;
`endif
      end else begin
         wen_o <= 1'b0;
         if (start_i) begin
            state      <= LOAD;
            ptr        <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            len_o      <= '0;
`ifdef LOADER_BRACKET_CHECK_EN
            nest       <= '0;
`endif
         end else begin
            if (do_write) begin
               wen_o   <= 1'b1;
               waddr_o <= ptr;
               wdata_o <= DATA_W'(wr_op);
            end
            if (do_finish) begin
               len_o  <= ptr;
               done_o <= 1'b1;
               state  <= DONE;
            end else if (do_write) begin
               ptr <= ptr + AW'(1);
`ifdef LOADER_BRACKET_CHECK_EN
               if (opcode == OP_JZ)
                  nest <= nest + NW'(1);
               else if (opcode == OP_JNZ)
                  nest <= nest - NW'(1);
`endif
            end
            if (fault) begin
               err_o      <= 1'b1;
               err_code_o <= fault_code;
               state      <= ERR;
            end
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: drivers queue expected memory writes,
// a negedge monitor checks each write's address, data and cycle.
module tb_program_loader;

   logic       clk_i      = 1'b0;
   logic       rst_i      = 1'b0;
   logic       start_i    = 1'b0;
   logic       rx_valid_i = 1'b0;
   logic [7:0] rx_data_i  = 8'h00;
   logic       rx_ready_o;
   logic       wen_o;
   logic [3:0] waddr_o;
   logic [7:0] wdata_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic [1:0] err_code_o;
   logic [3:0] len_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t q[$];
   wr_t mon_e;

   program_loader #(
      .DATA_W   (8),
      .DEPTH    (16),
      .MAX_NEST (7)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .rx_ready_o (rx_ready_o),
      .wen_o      (wen_o),
      .waddr_o    (waddr_o),
      .wdata_o    (wdata_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .err_code_o (err_code_o),
      .len_o      (len_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (wen_o !== 1'b0) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got wen=%b addr=%0d data=%0d cycle=%0d, required no write",
                     wen_o, waddr_o, wdata_o, cyc);
         end else begin
            mon_e = q.pop_front();
            if (wen_o !== 1'b1 || int'(waddr_o) != mon_e.addr || int'(wdata_o) != mon_e.data
                || cyc != mon_e.cyc) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                        waddr_o, wdata_o, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
      chk("busy_after_start", int'(busy_o), 1);
   endtask

   // Offers a byte until the loader takes it; w selects whether a write is expected.
   task automatic send_byte(input logic [7:0] b, input bit w, input int a, input int d);
      bit acc;
      acc        = 1'b0;
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk_i);
         if (rx_ready_o === 1'b1) begin
            acc = 1'b1;
            if (w) q.push_back('{a, d, cyc + 1});
         end
         tick(1);
      end
      rx_valid_i = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: byte 0x%02h not accepted within 20 cycles, required acceptance", b);
      end
   endtask

   task automatic drain(input string name);
      tick(3);
      chk(name, q.size(), 0);
   endtask

   task automatic chk_done(input string name, input int len);
      chk({name, "_done"}, int'(done_o), 1);
      chk({name, "_err"}, int'(err_o), 0);
      chk({name, "_len"}, int'(len_o), len);
      chk({name, "_ready_low"}, int'(rx_ready_o), 0);
   endtask

   task automatic chk_err(input string name, input int code);
      chk({name, "_err"}, int'(err_o), 1);
      chk({name, "_code"}, int'(err_code_o), code);
      chk({name, "_done"}, int'(done_o), 0);
      chk({name, "_ready_low"}, int'(rx_ready_o), 0);
   endtask

   initial begin
      tick(3);
      chk("rst_wen", int'(wen_o), 0);
      chk("rst_ready", int'(rx_ready_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_code", int'(err_code_o), 0);
      chk("rst_len", int'(len_o), 0);
      rst_i = 1'b1;
      tick(2);
      chk("idle_ready", int'(rx_ready_o), 0);

      // "+>[-]!"
      pulse_start();
      chk("load_ready", int'(rx_ready_o), 1);
      send_byte("+", 1, 0, 3);
      send_byte(">", 1, 1, 1);
      send_byte("[", 1, 2, 7);
      send_byte("-", 1, 3, 4);
      send_byte("]", 1, 4, 8);
      send_byte("!", 1, 5, 0);
      chk_done("basic", 5);
      rx_valid_i = 1'b1;
      rx_data_i  = "+";
      tick(2);
      rx_valid_i = 1'b0;
      chk("done_held", int'(done_o), 1);
      chk("len_held", int'(len_o), 5);
      drain("basic_pending");

      // "+ a\n-!"
      pulse_start();
      chk("restart_done_cleared", int'(done_o), 0);
      send_byte("+", 1, 0, 3);
      send_byte(" ", 0, 0, 0);
      send_byte("a", 0, 0, 0);
      send_byte(8'h0A, 0, 0, 0);
      send_byte("-", 1, 1, 4);
      send_byte("!", 1, 2, 0);
      chk_done("filter", 2);
      drain("filter_pending");

      // 15 '+' fill, terminator lands in the reserved last slot
      pulse_start();
      for (int i = 0; i < 15; i++) send_byte("+", 1, i, 3);
      send_byte("!", 1, 15, 0);
      chk_done("full", 15);
      drain("full_pending");

      // 15 '+' then one more: overflow
      pulse_start();
      for (int i = 0; i < 15; i++) send_byte("+", 1, i, 3);
      send_byte("+", 0, 0, 0);
      chk_err("overflow", 1);
      tick(3);
      chk("overflow_held", int'(err_code_o), 1);
      drain("overflow_pending");

      // gapped handshake, start from ERR
      pulse_start();
      chk("restart_err_cleared", int'(err_o), 0);
      send_byte("<", 1, 0, 2);
      tick(3);
      send_byte(".", 1, 1, 5);
      tick(3);
      send_byte(",", 1, 2, 6);
      tick(3);
      send_byte("!", 1, 3, 0);
      chk_done("gaps", 3);
      drain("gaps_pending");

      // start during LOAD: offered byte dropped, pointer back to 0, NUL terminates
      pulse_start();
      send_byte("+", 1, 0, 3);
      rx_valid_i = 1'b1;
      rx_data_i  = "-";
      start_i    = 1'b1;
      tick(1);
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      chk("restart_busy", int'(busy_o), 1);
      send_byte(">", 1, 0, 1);
      send_byte(8'h00, 1, 1, 0);
      chk_done("restart", 1);
      drain("restart_pending");

      // reset mid-load wins over start and handshake
      pulse_start();
      send_byte("+", 1, 0, 3);
      send_byte("+", 1, 1, 3);
      rst_i      = 1'b0;
      start_i    = 1'b1;
      rx_valid_i = 1'b1;
      rx_data_i  = "-";
      tick(1);
      rst_i      = 1'b1;
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      chk("midrst_busy", int'(busy_o), 0);
      chk("midrst_wen", int'(wen_o), 0);
      chk("midrst_len", int'(len_o), 0);
      pulse_start();
      send_byte("+", 1, 0, 3);
      send_byte("!", 1, 1, 0);
      chk_done("midrst", 1);
      drain("midrst_pending");

`ifdef LOADER_BRACKET_CHECK_EN
      pulse_start();
      send_byte("]", 0, 0, 0);
      chk_err("close", 2);
      drain("close_pending");

      pulse_start();
      send_byte("[", 1, 0, 7);
      send_byte("[", 1, 1, 7);
      send_byte("+", 1, 2, 3);
      send_byte("!", 0, 0, 0);
      chk_err("open", 3);
      drain("open_pending");

      pulse_start();
      for (int i = 0; i < 7; i++) send_byte("[", 1, i, 7);
      send_byte("[", 0, 0, 0);
      chk_err("nest", 3);
      drain("nest_pending");
`else
      pulse_start();
      send_byte("]", 1, 0, 8);
      send_byte("[", 1, 1, 7);
      send_byte("!", 1, 2, 0);
      chk_done("unchecked", 2);
      drain("unchecked_pending");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
